// File: rtl/ysyx_22050499_rf_scoreboard.sv
// Register file with two write-back ports, optional write-to-read forwarding,
// and a per-register pending (busy) scoreboard with a registered pending count.
module ysyx_22050499_rf_scoreboard #(
  parameter int NREGS      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BYPASS     = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [AW-1:0]         rs1,
  input  logic [AW-1:0]         rs2,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  wen0,
  input  logic [AW-1:0]         waddr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  wen1,
  input  logic [AW-1:0]         waddr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_rd,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt
);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_nxt;
  logic [AW:0]           cnt_nxt;
  logic                  wr0_act;
  logic                  wr1_act;
  logic                  rs1_hit0, rs1_hit1;
  logic                  rs2_hit0, rs2_hit1;

  // x0 is hardwired, so a write aimed at it is never "active".
  assign wr0_act = wen0 && (waddr0 != '0);
  assign wr1_act = wen1 && (waddr1 != '0);

  assign rs1_hit0 = (BYPASS != 0) && wr0_act && (waddr0 == rs1);
  assign rs1_hit1 = (BYPASS != 0) && wr1_act && (waddr1 == rs1);
  assign rs2_hit0 = (BYPASS != 0) && wr0_act && (waddr0 == rs2);
  assign rs2_hit1 = (BYPASS != 0) && wr1_act && (waddr1 == rs2);

  // Port 1 takes priority over port 0 when both forward to the same reader.
  always_comb begin
    rs1_data = regs[rs1];
    if (rs1_hit0) rs1_data = wdata0;
    if (rs1_hit1) rs1_data = wdata1;
    if (rs1 == '0) rs1_data = '0;
    rs2_data = regs[rs2];
    if (rs2_hit0) rs2_data = wdata0;
    if (rs2_hit1) rs2_data = wdata1;
    if (rs2 == '0) rs2_data = '0;
  end

  // A forwarded operand is no longer pending from the reader's point of view.
  assign rs1_busy = busy_q[rs1] && !(rs1_hit0 || rs1_hit1);
  assign rs2_busy = busy_q[rs2] && !(rs2_hit0 || rs2_hit1);

  // Write clears, then issue sets, so an issue in the same cycle wins.
  always_comb begin
    busy_nxt = busy_q;
    cnt_nxt  = '0;
    for (int i = 1; i < NREGS; i++) begin
      if ((wr0_act && waddr0 == AW'(i)) || (wr1_act && waddr1 == AW'(i)))
        busy_nxt[i] = 1'b0;
      if (iss_en && iss_rd == AW'(i))
        busy_nxt[i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    if (flush) busy_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr0_act) regs[waddr0] <= wdata0;
      if (wr1_act) regs[waddr1] <= wdata1;
      busy_q   <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule
